retired_rat_recover: RTL and testbench



---
 rtl/retired_rat_recover_pkg.sv | 23 ++
 rtl/retired_rat_recover_if.sv | 45 ++++
 rtl/retired_rat_recover_commit_resolve.sv | 55 +++++
 rtl/retired_rat_recover.sv | 186 ++++++++++++++++++
 tb/tb_retired_rat_recover.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/retired_rat_recover_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : retired_rat_recover_pkg
//  Description : Shared types for the retirement RAT: physical / architectural
//                register index types and the recovery FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package retired_rat_recover_pkg;

    localparam int unsigned c_DEF_PREG_W   = 6;
    localparam int unsigned c_DEF_NUM_ARCH = 32;

    typedef logic [c_DEF_PREG_W-1:0]             preg_t;
    typedef logic [$clog2(c_DEF_NUM_ARCH)-1:0]   arch_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } recover_state_t;

endpackage : retired_rat_recover_pkg
`default_nettype wire

// File: rtl/retired_rat_recover_if.sv
`default_nettype none
// ============================================================================
//  Module      : retired_rat_recover_if
//  Description : Commit, free-list and recovery-stream bundle of the
//                retirement RAT. slave = the RAT, master = its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface retired_rat_recover_if #(
    parameter int SS       = 2,
    parameter int NUM_ARCH = 32,
    parameter int PREG_W   = 6,
    parameter int COPY_BW  = 8
);
    localparam int c_AW = $clog2(NUM_ARCH);

    logic [SS-1:0]                   commit_valid;
    logic [SS-1:0][c_AW-1:0]         commit_arch_rd;
    logic [SS-1:0][PREG_W-1:0]       commit_preg;
    logic                            commit_ready;

    logic [SS-1:0]                   free_valid;
    logic [SS-1:0][PREG_W-1:0]       free_preg;

    logic                            flush_req;
    logic                            recover_valid;
    logic                            recover_ready;
    logic [c_AW-1:0]                 recover_base;
    logic [COPY_BW-1:0][PREG_W-1:0]  recover_data;
    logic                            recover_busy;
    logic                            recover_done;

    modport master (
        output commit_valid, commit_arch_rd, commit_preg, flush_req, recover_ready,
        input  commit_ready, free_valid, free_preg, recover_valid, recover_base,
               recover_data, recover_busy, recover_done
    );

    modport slave (
        input  commit_valid, commit_arch_rd, commit_preg, flush_req, recover_ready,
        output commit_ready, free_valid, free_preg, recover_valid, recover_base,
               recover_data, recover_busy, recover_done
    );

endinterface : retired_rat_recover_if
`default_nettype wire

// File: rtl/retired_rat_recover_commit_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : rrat_commit_resolve
//  Description : Combinational intra-group resolution for a multi-lane commit.
//                For each lane it finds the mapping that lane displaces (the
//                youngest older lane writing the same register, else the
//                table) and whether the lane's write survives (youngest wins).
//                Writes to x0 are dropped entirely.
//  Revision    : 1.0  initial release
// ============================================================================
module rrat_commit_resolve
    import retired_rat_recover_pkg::*;
#(
    parameter int SS     = 2,
    parameter int AW     = 5,
    parameter int PREG_W = 6
) (
    input  wire logic [SS-1:0]             i_valid,
    input  wire logic [SS-1:0][AW-1:0]     i_arch_rd,
    input  wire logic [SS-1:0][PREG_W-1:0] i_new_preg,
    input  wire logic [SS-1:0][PREG_W-1:0] i_tbl_preg,
    output logic      [SS-1:0][PREG_W-1:0] o_old_preg,
    output logic      [SS-1:0]             o_free_en,
    output logic      [SS-1:0]             o_wr_en
);

    logic [SS-1:0] w_live;

    // A lane is live when it commits and targets a register other than x0
    always_comb begin
        w_live = '0;
        for (int i = 0; i < SS; i++) begin
            w_live[i] = i_valid[i] && (i_arch_rd[i] != '0);
        end
    end

    // Older lanes forward their preg as the displaced mapping; younger lanes suppress the write
    always_comb begin
        o_old_preg = i_tbl_preg;
        o_free_en  = w_live;
        o_wr_en    = w_live;
        for (int i = 0; i < SS; i++) begin
            for (int j = 0; j < SS; j++) begin
                if ((j < i) && w_live[j] && (i_arch_rd[j] == i_arch_rd[i])) begin
                    o_old_preg[i] = i_new_preg[j];
                end
                if ((j > i) && w_live[j] && (i_arch_rd[j] == i_arch_rd[i])) begin
                    o_wr_en[i] = 1'b0;
                end
            end
        end
    end

endmodule : rrat_commit_resolve
`default_nettype wire

// File: rtl/retired_rat_recover.sv
`default_nettype none
// ============================================================================
//  Module      : retired_rat_recover
//  Description : Retirement register alias table. Applies multi-lane commits,
//                returns displaced physical registers to the free list one
//                cycle later, and on flush streams the committed map to the
//                speculative RAT in COPY_BW-entry beats (valid/ready).
//  Revision    : 1.0  initial release
// ============================================================================
module retired_rat_recover
    import retired_rat_recover_pkg::*;
#(
    parameter int SS       = 2,
    parameter int NUM_ARCH = 32,
    parameter int PREG_W   = 6,
    parameter int COPY_BW  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    retired_rat_recover_if.slave  bus
);

    localparam int c_AW        = $clog2(NUM_ARCH);
    localparam int c_NUM_BEATS = NUM_ARCH / COPY_BW;
    localparam int c_BEAT_W    = (c_NUM_BEATS > 1) ? $clog2(c_NUM_BEATS) : 1;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_NUM_BEATS - 1);
    localparam logic [c_AW-1:0]     c_BEAT_STEP = c_AW'(COPY_BW);

    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_COPY = COPY;
    localparam logic [1:0] c_ST_DONE = DONE;

    logic [PREG_W-1:0]              r_table     [NUM_ARCH];
    logic [PREG_W-1:0]              w_table_nxt [NUM_ARCH];

    logic                           w_commit_ready;
    logic [SS-1:0]                  w_fire;
    logic [SS-1:0][PREG_W-1:0]      w_tbl_rd;
    logic [SS-1:0][PREG_W-1:0]      w_old_preg;
    logic [SS-1:0]                  w_free_en;
    logic [SS-1:0]                  w_wr_en;

    logic [SS-1:0]                  r_free_valid;
    logic [SS-1:0][PREG_W-1:0]      r_free_preg;

    logic [1:0]                     r_state;
    logic [c_BEAT_W-1:0]            r_beat;
    logic [c_AW-1:0]                r_base;
    logic [COPY_BW-1:0][PREG_W-1:0] r_data;

    logic                           w_start;
    logic                           w_accept;
    logic                           w_last;
    logic                           w_load;
    logic [c_AW-1:0]                w_load_base;
    logic [COPY_BW-1:0][PREG_W-1:0] w_snap;

    assign w_commit_ready = (r_state == c_ST_IDLE);
    assign w_fire         = bus.commit_valid & {SS{w_commit_ready}};

    assign w_start     = (r_state == c_ST_IDLE) && bus.flush_req;
    assign w_accept    = (r_state == c_ST_COPY) && bus.recover_ready;
    assign w_last      = (r_beat == c_LAST_BEAT);
    assign w_load      = w_start || (w_accept && !w_last);
    assign w_load_base = w_start ? '0 : (r_base + c_BEAT_STEP);

    // Current mapping of each lane's destination, before any same-group update
    always_comb begin
        w_tbl_rd = '0;
        for (int i = 0; i < SS; i++) begin
            w_tbl_rd[i] = r_table[bus.commit_arch_rd[i]];
        end
    end

    rrat_commit_resolve #(
        .SS     (SS),
        .AW     (c_AW),
        .PREG_W (PREG_W)
    ) u_resolve (
        .i_valid    (w_fire),
        .i_arch_rd  (bus.commit_arch_rd),
        .i_new_preg (bus.commit_preg),
        .i_tbl_preg (w_tbl_rd),
        .o_old_preg (w_old_preg),
        .o_free_en  (w_free_en),
        .o_wr_en    (w_wr_en)
    );

    // Table as it will look after this cycle's commits; also feeds the flush snapshot
    always_comb begin
        w_table_nxt = r_table;
        for (int i = 0; i < SS; i++) begin
            if (w_wr_en[i]) begin
                w_table_nxt[bus.commit_arch_rd[i]] = bus.commit_preg[i];
            end
        end
    end

    // Gather the next beat's entries so a flush sees same-cycle commits
    always_comb begin
        w_snap = '0;
        for (int j = 0; j < COPY_BW; j++) begin
            w_snap[j] = w_table_nxt[w_load_base + c_AW'(j)];
        end
    end

    // Architectural map storage, identity after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_ARCH; k++) begin
                r_table[k] <= PREG_W'(k);
            end
        end else begin
            r_table <= w_table_nxt;
        end
    end

    // Displaced registers go to the free list one cycle after commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_free_valid <= '0;
            r_free_preg  <= '0;
        end else begin
            r_free_valid <= w_free_en;
            for (int i = 0; i < SS; i++) begin
                r_free_preg[i] <= w_free_en[i] ? w_old_preg[i] : '0;
            end
        end
    end

    // Recovery sequencer: IDLE -> COPY (one beat per handshake) -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_beat  <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.flush_req) begin
                        r_state <= c_ST_COPY;
                        r_beat  <= '0;
                        r_base  <= '0;
                    end
                end
                c_ST_COPY: begin
                    if (bus.recover_ready) begin
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_beat <= r_beat + c_BEAT_W'(1);
                            r_base <= w_load_base;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Beat payload register, reloaded on flush start and on each non-final acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= w_snap;
        end
    end

    assign bus.commit_ready  = w_commit_ready;
    assign bus.free_valid    = r_free_valid;
    assign bus.free_preg     = r_free_preg;
    assign bus.recover_valid = (r_state == c_ST_COPY);
    assign bus.recover_base  = r_base;
    assign bus.recover_data  = r_data;
    assign bus.recover_busy  = (r_state != c_ST_IDLE);
    assign bus.recover_done  = (r_state == c_ST_DONE);

endmodule : retired_rat_recover
`default_nettype wire

// File: tb/tb_retired_rat_recover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_retired_rat_recover
//  Description : Self-checking bench for retired_rat_recover. A reference map
//                predicts free-list returns and recovery beats; expectations
//                are queued at stimulus time and retired as the DUT responds.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_retired_rat_recover;
    import retired_rat_recover_pkg::*;

    localparam int c_SS      = 2;
    localparam int c_NARCH   = 32;
    localparam int c_PW      = 6;
    localparam int c_BW      = 8;
    localparam int c_NBEATS  = c_NARCH / c_BW;

    typedef struct {
        int                       due;
        logic [1:0]               fv;
        logic [1:0][c_PW-1:0]     fp;
    } free_t;

    typedef struct {
        logic [4:0]               base;
        logic [c_BW*c_PW-1:0]     data;
    } beat_t;

    logic clk;
    logic rst;

    retired_rat_recover_if #(.SS(c_SS), .NUM_ARCH(c_NARCH), .PREG_W(c_PW), .COPY_BW(c_BW)) bus ();

    retired_rat_recover #(.SS(c_SS), .NUM_ARCH(c_NARCH), .PREG_W(c_PW), .COPY_BW(c_BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    preg_t  m_table [c_NARCH];
    free_t  free_q [$];
    beat_t  beat_q [$];

    int n_vec  = 0;
    int n_err  = 0;
    int cyc_cnt = 0;
    int n_acc  = 0;
    int n_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!((|bus.commit_valid) && !bus.commit_ready))
                else $error("illegal commit while commit_ready low");
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < c_NARCH; k++) m_table[k] = preg_t'(k);
        free_q.delete();
        beat_q.delete();
    endtask

    task automatic push_beats();
        beat_t e;
        for (int b = 0; b < c_NBEATS; b++) begin
            e.base = 5'(b * c_BW);
            for (int j = 0; j < c_BW; j++) e.data[j*c_PW +: c_PW] = m_table[b*c_BW + j];
            beat_q.push_back(e);
        end
    endtask

    // One cycle of stimulus; reference map updated in lane order
    task automatic drive(input logic [1:0] cv, input int rd0, input int p0,
                         input int rd1, input int p1, input bit fl);
        free_t fe;
        int rd [2];
        int pr [2];
        rd[0] = rd0; rd[1] = rd1; pr[0] = p0; pr[1] = p1;
        bus.commit_valid      = cv;
        bus.commit_arch_rd[0] = 5'(rd0);
        bus.commit_arch_rd[1] = 5'(rd1);
        bus.commit_preg[0]    = 6'(p0);
        bus.commit_preg[1]    = 6'(p1);
        bus.flush_req         = fl;
        if (cv != 2'b00) begin
            fe.due = cyc_cnt + 1;
            fe.fv  = 2'b00;
            fe.fp  = '0;
            for (int i = 0; i < 2; i++) begin
                if (cv[i] && rd[i] != 0) begin
                    fe.fv[i] = 1'b1;
                    fe.fp[i] = m_table[rd[i]];
                    m_table[rd[i]] = preg_t'(pr[i]);
                end
            end
            free_q.push_back(fe);
        end
        if (fl) push_beats();
        @(posedge clk); #1;
        bus.commit_valid = '0;
        bus.flush_req    = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit toggle, input int reflush_k, output int cyc);
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        cyc = -1;
        for (int k = 1; k <= maxc; k++) begin
            if (toggle) bus.recover_ready = pat[(k-1) % 4];
            bus.flush_req = (k == reflush_k);
            @(negedge clk);
            if (bus.recover_done) begin
                cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        bus.flush_req     = 1'b0;
        bus.recover_ready = 1'b1;
        chk("done_seen", 64'(cyc >= 0), 64'd1);
    endtask

    task automatic post_done_idle();
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after_done", 64'(bus.recover_busy), 64'd0);
        chk("ready_after_done", 64'(bus.commit_ready), 64'd1);
    endtask

    // Scoreboard retirement: free-list returns and accepted recovery beats
    initial begin
        free_t   fe;
        beat_t   be;
        bit      hold;
        logic [4:0]           hold_base;
        logic [c_BW*c_PW-1:0] hold_data;
        hold = 1'b0;
        hold_base = '0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (free_q.size() > 0 && free_q[0].due <= cyc_cnt) begin
                    fe = free_q.pop_front();
                    chk("free_valid", 64'(bus.free_valid), 64'(fe.fv));
                    for (int i = 0; i < 2; i++)
                        if (fe.fv[i]) chk("free_preg", 64'(bus.free_preg[i]), 64'(fe.fp[i]));
                end
                if (bus.recover_valid) begin
                    chk("commit_ready_in_copy", 64'(bus.commit_ready), 64'd0);
                    if (hold) begin
                        chk("stall_base", 64'(bus.recover_base), 64'(hold_base));
                        chk("stall_data", 64'(bus.recover_data), 64'(hold_data));
                    end
                    if (bus.recover_ready) begin
                        hold = 1'b0;
                        n_acc++;
                        if (beat_q.size() == 0) begin
                            chk("beat_expected", 64'd0, 64'd1);
                        end else begin
                            be = beat_q.pop_front();
                            chk("beat_base", 64'(bus.recover_base), 64'(be.base));
                            chk("beat_data", 64'(bus.recover_data), 64'(be.data));
                        end
                    end else begin
                        hold      = 1'b1;
                        hold_base = bus.recover_base;
                        hold_data = bus.recover_data;
                    end
                end else begin
                    hold = 1'b0;
                end
                if (bus.recover_done) n_done++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acc0;
        int done0;

        rst                = 1'b1;
        bus.commit_valid   = '0;
        bus.commit_arch_rd = '0;
        bus.commit_preg    = '0;
        bus.flush_req      = 1'b0;
        bus.recover_ready  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_commit_ready", 64'(bus.commit_ready), 64'd1);
        chk("rst_busy", 64'(bus.recover_busy), 64'd0);
        chk("rst_valid", 64'(bus.recover_valid), 64'd0);
        chk("rst_done", 64'(bus.recover_done), 64'd0);
        chk("rst_free_valid", 64'(bus.free_valid), 64'd0);
        chk("rst_free_preg", 64'(bus.free_preg), 64'd0);

        // Identity flush with ready high
        acc0 = n_acc; done0 = n_done;
        drive(2'b00, 0, 0, 0, 0, 1'b1);
        wait_done(20, 1'b0, 0, cyc);
        chk("flush1_done_cycle", 64'(cyc), 64'(c_NBEATS + 1));
        post_done_idle();
        chk("flush1_beats", 64'(n_acc - acc0), 64'(c_NBEATS));
        chk("flush1_dones", 64'(n_done - done0), 64'd1);

        // Single commit r3 -> 40, then flush
        drive(2'b01, 3, 40, 0, 0, 1'b0);
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 0, 1'b1);
        wait_done(20, 1'b0, 0, cyc);
        post_done_idle();

        // Dual commit both to r5, then r5 -> 42 alongside an x0 write
        drive(2'b11, 5, 40, 5, 41, 1'b0);
        drive(2'b11, 5, 42, 0, 50, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Recovery with a stalling consumer
        acc0 = n_acc;
        drive(2'b00, 0, 0, 0, 0, 1'b1);
        wait_done(40, 1'b1, 0, cyc);
        chk("toggle_done_cycle", 64'(cyc), 64'd9);
        chk("toggle_beats", 64'(n_acc - acc0), 64'(c_NBEATS));
        post_done_idle();

        // Flush in the same cycle as a commit, then a redundant flush mid-COPY
        acc0 = n_acc; done0 = n_done;
        drive(2'b01, 7, 60, 0, 0, 1'b1);
        wait_done(20, 1'b0, 2, cyc);
        chk("flush_commit_done_cycle", 64'(cyc), 64'(c_NBEATS + 1));
        post_done_idle();
        chk("reflush_beats", 64'(n_acc - acc0), 64'(c_NBEATS));
        chk("reflush_dones", 64'(n_done - done0), 64'd1);
        chk("reflush_queue_empty", 64'(beat_q.size()), 64'd0);

        // Reset while beat 2 is presented
        bus.recover_ready = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 1'b1);
        repeat (2) begin
            bus.recover_ready = 1'b1;
            @(posedge clk); #1;
            bus.recover_ready = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_base", 64'(bus.recover_base), 64'd16);
        chk("pre_rst_valid", 64'(bus.recover_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.recover_ready = 1'b1;
        model_reset();
        done0 = n_done;
        @(negedge clk);
        chk("midrst_busy", 64'(bus.recover_busy), 64'd0);
        chk("midrst_valid", 64'(bus.recover_valid), 64'd0);
        chk("midrst_done", 64'(bus.recover_done), 64'd0);
        chk("midrst_commit_ready", 64'(bus.commit_ready), 64'd1);
        chk("midrst_free_valid", 64'(bus.free_valid), 64'd0);
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 64'(n_done - done0), 64'd0);

        // Commit presented during reset must not reach the free list or the map
        rst = 1'b1;
        bus.commit_valid      = 2'b01;
        bus.commit_arch_rd[0] = 5'd9;
        bus.commit_preg[0]    = 6'd61;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.commit_valid = '0;
        @(negedge clk);
        chk("rst_commit_free_valid", 64'(bus.free_valid), 64'd0);

        // Map must be identity again
        drive(2'b00, 0, 0, 0, 0, 1'b1);
        wait_done(20, 1'b0, 0, cyc);
        chk("post_rst_done_cycle", 64'(cyc), 64'(c_NBEATS + 1));
        post_done_idle();
        chk("final_queue_empty", 64'(beat_q.size() + free_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_retired_rat_recover
`default_nettype wire
